// File: rtl/item_eat_detector.sv
// item_eat_detector
//   Watches Pac-Man's tile, looks up the item stored there through a
//   combinational read port, and on a dot/energizer issues a one-cycle
//   eaten event, adds score and holds Pac-Man for a number of frames.
//
//   Optional feature macro: ITEM_EAT_EXTRA_LIFE_EN
//     defined   -> o_extra_life pulses once when the score first reaches
//                  EXTRA_LIFE_SCORE (re-armed only by i_score_clear/reset)
//     undefined -> o_extra_life is tied low
//
//   Handshake note: there is no valid/ready pair here. The item read port
//   is a plain combinational lookup (o_rd_x/o_rd_y -> i_rd_item, same
//   cycle), and every event output is a one-cycle pulse with no
//   back-pressure; the consumer must take it in the cycle it is high.
//
//   o_dbg_state exposes the FSM state (0 IDLE, 1 LOOKUP, 2 COMMIT, 3 FREEZE).
module item_eat_detector #(
  parameter int SCORE_W          = 20,
  parameter int SCORE_DOT        = 10,
  parameter int SCORE_ENERGIZER  = 50,
  parameter int PAUSE_DOT        = 1,
  parameter int PAUSE_ENERGIZER  = 3,
  parameter int EXTRA_LIFE_SCORE = 10000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_enable,
  input  logic               i_item_reload,
  input  logic               i_score_clear,
  input  logic [5:0]         i_pac_x,
  input  logic [5:0]         i_pac_y,
  output logic [5:0]         o_rd_x,
  output logic [5:0]         o_rd_y,
  input  logic [1:0]         i_rd_item,
  output logic               o_item_eaten,
  output logic [1:0]         o_item_eaten_type,
  output logic [5:0]         o_item_x,
  output logic [5:0]         o_item_y,
  output logic               o_energizer_event,
  output logic               o_pac_freeze,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_extra_life,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2,
    FREEZE = 2'd3
  } state_t;

  localparam logic [1:0] ITEM_DOT       = 2'd1;
  localparam logic [1:0] ITEM_ENERGIZER = 2'd2;

  localparam logic [7:0]       FRZ_DOT   = 8'(PAUSE_DOT);
  localparam logic [7:0]       FRZ_ENERG = 8'(PAUSE_ENERGIZER);
  localparam logic [SCORE_W:0] PTS_DOT   = (SCORE_W+1)'(SCORE_DOT);
  localparam logic [SCORE_W:0] PTS_ENERG = (SCORE_W+1)'(SCORE_ENERGIZER);

  state_t             state_q, state_d;
  logic [5:0]         last_x_q, last_y_q;
  logic               last_vld_q;
  logic [5:0]         rd_x_q, rd_y_q;
  logic [1:0]         type_q;
  logic [7:0]         frz_q, frz_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               tile_new;
  logic               tile_in_range;
  logic               capture_tile;
  logic               commit_ok;
  logic               is_energ;
  logic [SCORE_W:0]   score_add;
  logic [SCORE_W:0]   score_sum;

  // Tile-change detection and commit qualification
  always_comb begin
    tile_new      = i_enable && (!last_vld_q || (i_pac_x != last_x_q) || (i_pac_y != last_y_q));
    tile_in_range = (i_pac_x <= 6'd35) && (i_pac_y <= 6'd27);
    capture_tile  = (state_q == IDLE) && tile_new && !i_item_reload;
    commit_ok     = (state_q == COMMIT) && !i_item_reload;
    is_energ      = (type_q == ITEM_ENERGIZER);
  end

  // Next state and freeze counter; reload overrides everything
  always_comb begin
    state_d = state_q;
    frz_d   = frz_q;
    if (i_item_reload) begin
      state_d = IDLE;
      frz_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tile_new && tile_in_range) state_d = LOOKUP;
        end
        LOOKUP: begin
          if ((i_rd_item == ITEM_DOT) || (i_rd_item == ITEM_ENERGIZER)) state_d = COMMIT;
          else                                                           state_d = IDLE;
        end
        COMMIT: begin
          // a frame tick in this cycle is deliberately not counted
          frz_d   = is_energ ? FRZ_ENERG : FRZ_DOT;
          state_d = (frz_d != 8'd0) ? FREEZE : IDLE;
        end
        FREEZE: begin
          if (i_frame_tick) begin
            if (frz_q <= 8'd1) begin
              frz_d   = 8'd0;
              state_d = IDLE;
            end else begin
              frz_d = frz_q - 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating score update; clear beats a coincident commit
  always_comb begin
    score_add = '0;
    if (commit_ok) score_add = is_energ ? PTS_ENERG : PTS_DOT;
    score_sum = {1'b0, score_q} + score_add;
    score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    if (i_score_clear) score_d = '0;
  end

  // FSM, counter and score registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      frz_q   <= 8'd0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      frz_q   <= frz_d;
      score_q <= score_d;
    end
  end

  // Last-tile tracking, read address and sampled item type
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_x_q   <= 6'd0;
      last_y_q   <= 6'd0;
      last_vld_q <= 1'b0;
      rd_x_q     <= 6'd0;
      rd_y_q     <= 6'd0;
      type_q     <= 2'd0;
    end else begin
      if (i_item_reload) begin
        last_vld_q <= 1'b0;
      end else if (capture_tile) begin
        last_x_q   <= i_pac_x;
        last_y_q   <= i_pac_y;
        last_vld_q <= 1'b1;
        // tunnel tiles only update the last tile; the read address is kept
        if (tile_in_range) begin
          rd_x_q <= i_pac_x;
          rd_y_q <= i_pac_y;
        end
      end
      if (state_q == LOOKUP) type_q <= i_rd_item;
    end
  end

`ifdef ITEM_EAT_EXTRA_LIFE_EN
  logic awarded_q;
  logic extra_life_q;

  // One-shot award the cycle after the score first reaches the threshold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      awarded_q    <= 1'b0;
      extra_life_q <= 1'b0;
    end else if (i_score_clear) begin
      awarded_q    <= 1'b0;
      extra_life_q <= 1'b0;
    end else begin
      extra_life_q <= 1'b0;
      if (!awarded_q && (64'(score_q) >= 64'(EXTRA_LIFE_SCORE))) begin
        awarded_q    <= 1'b1;
        extra_life_q <= 1'b1;
      end
    end
  end

  assign o_extra_life = extra_life_q;
`else
  assign o_extra_life = 1'b0;
`endif

  assign o_rd_x            = rd_x_q;
  assign o_rd_y            = rd_y_q;
  assign o_item_eaten      = commit_ok;
  assign o_item_eaten_type = commit_ok ? type_q : 2'd0;
  assign o_item_x          = commit_ok ? rd_x_q : 6'd0;
  assign o_item_y          = commit_ok ? rd_y_q : 6'd0;
  assign o_energizer_event = commit_ok && is_energ;
  assign o_pac_freeze      = (state_q == FREEZE) && !i_item_reload;
  assign o_score           = score_q;
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_item_eat_detector.sv
// tb_item_eat_detector
//   Directed bench for item_eat_detector. dut drives the default
//   configuration; dut8 uses SCORE_W=8, zero pauses and a low extra-life
//   threshold to reach saturation and the award quickly.
module tb_item_eat_detector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared controls
  logic tick = 1'b0;
  logic reload = 1'b0;
  logic sclr = 1'b0;

  // main instance
  logic        en = 1'b0;
  logic [5:0]  pac_x = 6'd0, pac_y = 6'd0;
  logic [5:0]  rd_x, rd_y;
  logic [1:0]  rd_item;
  logic        eaten, ev_en, frz, xl;
  logic [1:0]  etype, st;
  logic [5:0]  ix, iy;
  logic [19:0] score;

  // 8-bit score instance
  logic        en8 = 1'b0;
  logic [5:0]  p8_x = 6'd0, p8_y = 6'd0;
  logic [5:0]  rd8_x, rd8_y;
  logic [1:0]  item8;
  logic        eaten8, ev8, frz8, xl8;
  logic [1:0]  etype8, st8;
  logic [5:0]  ix8, iy8;
  logic [7:0]  score8;

  // item map seen by each instance
  function automatic logic [1:0] map_main(input logic [5:0] x, input logic [5:0] y);
    if (x == 6'd5  && y == 6'd3) return 2'd1;
    if (x == 6'd26 && y == 6'd1) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] map8(input logic [5:0] x);
    if (x == 6'd10) return 2'd2;
    if (x == 6'd11) return 2'd1;
    return 2'd0;
  endfunction

  assign rd_item = map_main(rd_x, rd_y);
  assign item8   = map8(rd8_x);

  item_eat_detector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en),
    .i_item_reload(reload), .i_score_clear(sclr),
    .i_pac_x(pac_x), .i_pac_y(pac_y), .o_rd_x(rd_x), .o_rd_y(rd_y),
    .i_rd_item(rd_item), .o_item_eaten(eaten), .o_item_eaten_type(etype),
    .o_item_x(ix), .o_item_y(iy), .o_energizer_event(ev_en),
    .o_pac_freeze(frz), .o_score(score), .o_extra_life(xl), .o_dbg_state(st)
  );

  item_eat_detector #(
    .SCORE_W(8), .PAUSE_DOT(0), .PAUSE_ENERGIZER(0), .EXTRA_LIFE_SCORE(200)
  ) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_enable(en8),
    .i_item_reload(reload), .i_score_clear(sclr),
    .i_pac_x(p8_x), .i_pac_y(p8_y), .o_rd_x(rd8_x), .o_rd_y(rd8_y),
    .i_rd_item(item8), .o_item_eaten(eaten8), .o_item_eaten_type(etype8),
    .o_item_x(ix8), .o_item_y(iy8), .o_energizer_event(ev8),
    .o_pac_freeze(frz8), .o_score(score8), .o_extra_life(xl8), .o_dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int n_eat = 0;
  int n_xl = 0;
  int n_xl8 = 0;
  int base;

  // pulse counters sampled on the active edge (inputs move 1ns later)
  always @(posedge clk) begin
    if (eaten) n_eat = n_eat + 1;
    if (xl)    n_xl  = n_xl + 1;
    if (xl8)   n_xl8 = n_xl8 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    chk("rst_eaten", 32'(eaten), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_freeze", 32'(frz), 0);
    chk("rst_rd_x", 32'(rd_x), 0);
    chk("rst_xl", 32'(xl), 0);
    rst_n = 1'b1;
    step();

    // dot at (5,3): LOOKUP after one edge, pulse during the next cycle
    pac_x = 6'd5; pac_y = 6'd3; en = 1'b1;
    step();
    chk("dot_lookup_state", 32'(st), 1);
    chk("dot_rd_x", 32'(rd_x), 5);
    step();
    chk("dot_eaten", 32'(eaten), 1);
    chk("dot_type", 32'(etype), 1);
    chk("dot_x", 32'(ix), 5);
    chk("dot_y", 32'(iy), 3);
    chk("dot_no_energ", 32'(ev_en), 0);
    step();
    chk("dot_score", 32'(score), 10);
    chk("dot_freeze_on", 32'(frz), 1);
    chk("dot_pulse_one", 32'(eaten), 0);
    steps(3);
    chk("dot_freeze_hold", 32'(frz), 1);
    frame();
    chk("dot_freeze_off", 32'(frz), 0);
    chk("dot_idle", 32'(st), 0);

    // energizer at (26,1); a tick in the COMMIT cycle does not count
    pac_x = 6'd26; pac_y = 6'd1;
    steps(2);
    chk("en_eaten", 32'(eaten), 1);
    chk("en_type", 32'(etype), 2);
    chk("en_event", 32'(ev_en), 1);
    chk("en_x", 32'(ix), 26);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("en_score", 32'(score), 60);
    chk("en_freeze_on", 32'(frz), 1);
    steps(2);
    frame();
    chk("en_freeze_after_1", 32'(frz), 1);
    steps(2);
    frame();
    chk("en_freeze_after_2", 32'(frz), 1);
    steps(2);
    frame();
    chk("en_freeze_after_3", 32'(frz), 0);

    // back on (5,3) and stay 100 cycles: exactly one eat
    base = n_eat;
    pac_x = 6'd5; pac_y = 6'd3;
    for (int i = 0; i < 20; i++) begin
      frame();
      steps(4);
    end
    chk("stay_one_eat", 32'(n_eat - base), 1);
    chk("stay_score", 32'(score), 70);
    pac_y = 6'd4;
    steps(4);
    chk("move_rd_y", 32'(rd_y), 4);
    chk("move_no_eat", 32'(n_eat - base), 1);
    pac_y = 6'd3;
    steps(2);
    chk("return_eaten", 32'(eaten), 1);
    step();
    frame();
    chk("return_score", 32'(score), 80);

    // reload in the COMMIT cycle suppresses everything but keeps score
    pac_x = 6'd26; pac_y = 6'd1;
    steps(2);
    reload = 1'b1; en = 1'b0;
    #1;
    chk("reload_no_eaten", 32'(eaten), 0);
    chk("reload_no_event", 32'(ev_en), 0);
    chk("reload_no_freeze", 32'(frz), 0);
    step();
    reload = 1'b0;
    chk("reload_score", 32'(score), 80);
    chk("reload_idle", 32'(st), 0);

    // tunnel tile: no lookup, read address untouched
    base = n_eat;
    pac_x = 6'd40; pac_y = 6'd3; en = 1'b1;
    steps(5);
    chk("tunnel_idle", 32'(st), 0);
    chk("tunnel_rd_x", 32'(rd_x), 26);
    chk("tunnel_no_eat", 32'(n_eat - base), 0);

    // score clear coincident with COMMIT wins
    pac_x = 6'd5; pac_y = 6'd3;
    steps(2);
    chk("clr_eaten", 32'(eaten), 1);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    chk("clr_score", 32'(score), 0);
    chk("clr_freeze_on", 32'(frz), 1);
    frame();
    chk("clr_freeze_off", 32'(frz), 0);

    // 8-bit score: five energizers to 250, then dots saturate at 255
    en8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p8_x = 6'd10; p8_y = 6'(i);
      steps(3);
    end
    chk("sat_preload", 32'(score8), 250);
    chk("sat_no_freeze", 32'(frz8), 0);
    p8_x = 6'd11; p8_y = 6'd0;
    steps(3);
    chk("sat_first", 32'(score8), 255);
    chk("sat_idle", 32'(st8), 0);
    p8_x = 6'd11; p8_y = 6'd1;
    steps(3);
    chk("sat_hold", 32'(score8), 255);
    steps(2);

    chk("xl_main_never", 32'(n_xl), 0);
`ifdef ITEM_EAT_EXTRA_LIFE_EN
    chk("xl8_single", 32'(n_xl8), 1);
`else
    chk("xl8_tied_low", 32'(n_xl8), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/item_eat_detector.md
Name: item_eat_detector

Overview:
Upstream feeder of the items controller. Watches Pac-Man's current tile and reads the item stored at that tile through a read port. When Pac-Man enters a tile holding a dot or energizer, it:
- issues a one-cycle eaten event with item type and tile coordinates,
- accumulates score,
- freezes Pac-Man movement for a fixed number of frames (original-arcade eat stall).

Parameters:
SCORE_W, 20, width of o_score
SCORE_DOT, 10, points per dot
SCORE_ENERGIZER, 50, points per energizer
PAUSE_DOT, 1, freeze frames after a dot (0 = none)
PAUSE_ENERGIZER, 3, freeze frames after an energizer (0 = none)
EXTRA_LIFE_SCORE, 10000, threshold for the optional extra-life award

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_tick  in  1  one-cycle pulse per video frame
i_enable  in  1  detection enabled (gameplay running)
i_item_reload  in  1  level (re)load; same cycle the items controller reloads its map
i_score_clear  in  1  new game; score to 0
i_pac_x  in  6  Pac-Man tile, first map index, valid range 0..35
i_pac_y  in  6  Pac-Man tile, second map index, valid range 0..27
o_rd_x  out  6  item read address, first index
o_rd_y  out  6  item read address, second index
i_rd_item  in  2  item at (o_rd_x,o_rd_y), combinational, same cycle; 0 none, 1 dot, 2 energizer, 3 treated as none
o_item_eaten  out  1  one-cycle eaten pulse
o_item_eaten_type  out  2  item type, valid with pulse
o_item_x  out  6  eaten tile, first index
o_item_y  out  6  eaten tile, second index
o_energizer_event  out  1  one-cycle pulse with an energizer eat (ghost fright trigger)
o_pac_freeze  out  1  high while the eat stall is active
o_score  out  SCORE_W  accumulated score
o_extra_life  out  1  one-cycle award pulse (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; last-tile-valid flag 0.
- States:
  - IDLE: if i_enable and (last-tile invalid or (i_pac_x,i_pac_y) differs from last tile), register tile into o_rd_x/o_rd_y and last tile, set last-tile valid, go to LOOKUP.
  - IDLE, out-of-range tile (x>35 or y>27, tunnel): update last tile, no lookup, stay in IDLE.
  - LOOKUP: sample i_rd_item. Type 1 or 2 goes to COMMIT; otherwise returns to IDLE.
  - COMMIT (one cycle): assert o_item_eaten, type, and o_item_x/o_item_y = o_rd_x/o_rd_y. Add SCORE_DOT or SCORE_ENERGIZER to o_score. Energizer also pulses o_energizer_event. Load freeze counter with PAUSE_DOT or PAUSE_ENERGIZER. Next state is FREEZE if the count is nonzero, else IDLE.
  - FREEZE: o_pac_freeze = 1. Decrement on each i_frame_tick; go to IDLE on the tick that reaches 0.
- Latency: tile change sampled at edge N → LOOKUP at N+1 → o_item_eaten high during cycle N+2.
- No double eat: the same tile is never re-looked-up until Pac-Man leaves it. The cleared map entry only becomes visible one cycle after COMMIT.
- i_enable low: IDLE does not start lookups; LOOKUP, COMMIT and FREEZE complete normally.
- i_item_reload: highest priority.
  - Forces IDLE, clears the freeze counter and last-tile valid, deasserts o_pac_freeze.
  - Suppresses any COMMIT pulse in that cycle.
  - Score is untouched.
- i_score_clear: o_score ← 0. If it coincides with a COMMIT, the result is 0; clear wins.
- Score arithmetic: unsigned, saturates at 2^SCORE_W−1; never wraps.
- i_frame_tick arriving in the COMMIT cycle is ignored for the countdown.

Optional Feature:
ITEM_EAT_EXTRA_LIFE_EN
- Defined: o_extra_life pulses for one cycle in the cycle after o_score first becomes ≥ EXTRA_LIFE_SCORE. An awarded flag prevents repeats; only i_score_clear or reset clears the flag, not i_item_reload.
- Undefined: o_extra_life is tied to 0 and no flag logic is built.

Test Plan:
- Reset, then enable with Pac at (5,3) where i_rd_item=1 → o_item_eaten pulse 2 cycles later, type=1, x=5, y=3; o_score=10; o_pac_freeze high until the next i_frame_tick.
- Energizer at (26,1) → type=2, o_energizer_event pulse, o_score +50, o_pac_freeze held for exactly 3 frame ticks.
- Pac stays on (5,3) for 100 cycles after eating, with the bench still returning 1 → exactly one eaten pulse. Move to (5,4) and back to (5,3) → a new lookup occurs.
- i_item_reload asserted during the COMMIT cycle → no o_item_eaten, o_pac_freeze 0, o_score unchanged. Pac at (40,3) → no lookup, no pulse.
- Preload score near max with SCORE_W=8 (score 250, dot) → o_score saturates at 255. i_score_clear coincident with COMMIT → o_score=0.
- With ITEM_EAT_EXTRA_LIFE_EN, score 9995 plus a dot → o_score=10005, a single o_extra_life pulse, no pulse on further eats.
